chnl_master_node: RTL and testbench
===================================

Name: chnl_master_node

Overview:
- Transmit-side channel node: the initiator that feeds one channel slave node across the data/parity/valid/wait interface.
- Buffers 32-bit words pushed by an upstream stimulus/register source, generates even parity, and presents words to the slave with valid_o.
- Holds each word stable until the slave accepts it (valid_o && !wait_i).
- Stalls on a sticky parity error reported back by the slave and exposes transfer status to the register block.

Parameters:
- DEPTH, 16, internal buffer depth in words; power of two, 2..64.
- GAP_W, 4, width of the programmable inter-word idle gap field.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- push_data_i  in  32  word from upstream
- push_i  in  1  write push_data_i into buffer; ignored while full_o
- full_o  out  1  buffer full
- freeslot_o  out  7  free buffer entries, 0..DEPTH
- en_i  in  1  channel enable; 0 = finish nothing new, valid_o forced low
- gap_i  in  GAP_W  idle cycles inserted after each accepted word
- data_o  out  32  word to slave
- data_p_o  out  1  parity bit: ^{data_o,data_p_o} == 0
- valid_o  out  1  word valid to slave
- wait_i  in  1  slave back-pressure
- parity_err_i  in  1  sticky parity error from slave
- busy_o  out  1  state != IDLE or buffer non-empty
- sent_cnt_o  out  16  accepted-word counter, wraps 0xFFFF->0
- cnt_clr_i  in  1  synchronous clear of sent_cnt_o

Behaviour:
- Reset values: valid_o=0, data_o=0, data_p_o=0, full_o=0, freeslot_o=DEPTH, busy_o=0, sent_cnt_o=0, FSM=IDLE, buffer empty.
- Buffer: synchronous FIFO. Push while full is dropped with no state change. Simultaneous push and pop while full is allowed: the pop frees a slot the same cycle. Pointers wrap modulo DEPTH.
- data_p_o = ^data_o, combinational from the registered data_o.
- FSM states: IDLE, SEND, GAP, ERR.
- IDLE -> SEND when en_i && buffer non-empty && !parity_err_i. On that edge the head word is loaded into data_o and valid_o=1 from the next cycle (1-cycle latency from non-empty to valid_o).
- SEND: data_o/valid_o held stable while wait_i=1. Acceptance = valid_o && !wait_i. On acceptance: pop, sent_cnt_o+1.
  - If gap_i==0, buffer still non-empty and en_i: load the next word, remain SEND (back-to-back, one word per cycle).
  - If gap_i==0 otherwise: valid_o=0, go IDLE.
  - If gap_i!=0: valid_o=0, go GAP with counter=gap_i.
- GAP: counter decrements each cycle; at 0 go IDLE. gap_i is sampled only on acceptance.
- ERR: entered from any state when parity_err_i=1; has priority over all other transitions.
  - valid_o=0 next cycle. The un-accepted word stays at the buffer head and is not popped.
  - Leave to IDLE when parity_err_i=0. The held word is then resent.
- en_i falling in SEND with valid_o=1 and wait_i=1: word is withdrawn (valid_o=0, no pop), go IDLE.
- cnt_clr_i and acceptance in the same cycle: count becomes 0 (clear wins).
- Reset asserted mid-transfer: all state cleared immediately; buffered words are lost.

Optional Feature:
- Macro PARITY_INJECT_EN.
- When defined: add port inj_i (in, 1). When inj_i=1 as a word is loaded into data_o, data_p_o is inverted for that word only, and an inject flag is held with the word until acceptance or withdrawal.
- When not defined: no port, parity always correct.

Decomposition:
- Shared package chnl_pkg holds:
  - FSM state enum (IDLE, SEND, GAP, ERR)
  - DATA_W=32
  - CNT_W=16
  - function parity32(data) returning the even-parity bit.
- One natural sub-module: chnl_tx_fifo (active-high async reset sync FIFO with full/empty/freeslot). It is shared with future master-side blocks.

Test Plan:
- Push 0x00000001, 0x00000003 with wait_i=0, gap_i=0 -> valid_o high 2 consecutive cycles, data_p_o=1 then 0, sent_cnt_o=2, freeslot_o returns to 16.
- Push 0xA5A5A5A5 with wait_i=1 for 5 cycles then 0 -> data_o stable 6 cycles, single acceptance, sent_cnt_o=1.
- gap_i=3, push 3 words -> valid_o pulses separated by exactly 3 low cycles.
- parity_err_i asserted during SEND with wait_i=1 -> valid_o low next cycle, freeslot unchanged; release -> same word resent and accepted once.
- Push 17 words into DEPTH=16 with en_i=0 -> full_o=1, 17th dropped, freeslot_o=0; enable -> exactly 16 words sent in order.
- With PARITY_INJECT_EN, inj_i on word 0x0 -> data_p_o=1 for that word only; next word 0x0 has data_p_o=0.

Source files
------------

// File: rtl/chnl_pkg.sv
// rtl/chnl_pkg.sv - shared types, widths and parity helper for channel nodes
package chnl_pkg;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      ERR  = 2'd3
   } state_t;

   // Even-parity bit: XOR of the word together with this bit is zero.
   function automatic logic parity32(input logic [DATA_W-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/chnl_tx_fifo.sv
// rtl/chnl_tx_fifo.sv - sync word FIFO with full/empty/freeslot and head/next peek
module chnl_tx_fifo import chnl_pkg::*; #(
   parameter int DEPTH = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              push_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] head_o,
   output logic [DATA_W-1:0] next_o,
   output logic              full_o,
   output logic              empty_o,
   output logic              more_o,
   output logic [6:0]        freeslot_o
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     wr_ptr;
   logic [6:0]        count;
   logic              do_pop;
   logic              do_push;

   assign full_o     = (count == 7'(DEPTH));
   assign empty_o    = (count == 7'd0);
   assign more_o     = (count > 7'd1);
   assign freeslot_o = 7'(DEPTH) - count;
   assign head_o     = mem[rd_ptr];
   assign next_o     = mem[rd_ptr + AW'(1)];

   // A pop in the same cycle frees the slot a push into a full buffer needs.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + {6'd0, do_push} - {6'd0, do_pop};
      end
   end

endmodule

// File: rtl/chnl_master_node.sv
// rtl/chnl_master_node.sv - transmit-side channel node feeding one slave over data/parity/valid/wait
// Optional parity fault injection port inj_i is built when PARITY_INJECT_EN is defined.
module chnl_master_node import chnl_pkg::*; #(
   parameter int DEPTH = 16,
   parameter int GAP_W = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic              push_i,
   output logic              full_o,
   output logic [6:0]        freeslot_o,
   input  logic              en_i,
   input  logic [GAP_W-1:0]  gap_i,
   output logic [DATA_W-1:0] data_o,
   output logic              data_p_o,
   output logic              valid_o,
   input  logic              wait_i,
   input  logic              parity_err_i,
   output logic              busy_o,
   output logic [CNT_W-1:0]  sent_cnt_o,
   input  logic              cnt_clr_i
`ifdef PARITY_INJECT_EN
   ,
   input  logic              inj_i
`endif
);

   state_t            state, state_n;
   logic [DATA_W-1:0] data_n;
   logic              valid_n;
   logic [GAP_W-1:0]  gap_cnt, gap_n;
   logic              pop, load, accept;
   logic [DATA_W-1:0] head, next;
   logic              empty, more;

   chnl_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (push_i),
      .push_data_i (push_data_i),
      .pop_i       (pop),
      .head_o      (head),
      .next_o      (next),
      .full_o      (full_o),
      .empty_o     (empty),
      .more_o      (more),
      .freeslot_o  (freeslot_o)
   );

   always_comb begin
      state_n = state;
      data_n  = data_o;
      valid_n = valid_o;
      gap_n   = gap_cnt;
      pop     = 1'b0;
      load    = 1'b0;
      accept  = 1'b0;
      if (parity_err_i) begin
         state_n = ERR;
         valid_n = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (en_i && !empty) begin
                  data_n  = head;
                  valid_n = 1'b1;
                  load    = 1'b1;
                  state_n = SEND;
               end
            end
            SEND: begin
               if (valid_o && !wait_i) begin
                  accept = 1'b1;
                  pop    = 1'b1;
                  if (gap_i != '0) begin
                     gap_n   = gap_i;
                     valid_n = 1'b0;
                     state_n = GAP;
                  end else if (more && en_i) begin
                     data_n = next;
                     load   = 1'b1;
                  end else begin
                     valid_n = 1'b0;
                     state_n = IDLE;
                  end
               end else if (!en_i || !valid_o) begin
                  valid_n = 1'b0;
                  state_n = IDLE;
               end
            end
            GAP: begin
               // The last gap cycle launches directly so exactly gap_i idle cycles separate words.
               if (gap_cnt <= GAP_W'(1)) begin
                  gap_n = '0;
                  if (en_i && !empty) begin
                     data_n  = head;
                     valid_n = 1'b1;
                     load    = 1'b1;
                     state_n = SEND;
                  end else begin
                     state_n = IDLE;
                  end
               end else begin
                  gap_n = gap_cnt - GAP_W'(1);
               end
            end
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= IDLE;
         data_o     <= '0;
         valid_o    <= 1'b0;
         gap_cnt    <= '0;
         sent_cnt_o <= '0;
      end else begin
         state   <= state_n;
         data_o  <= data_n;
         valid_o <= valid_n;
         gap_cnt <= gap_n;
         if (cnt_clr_i)   sent_cnt_o <= '0;
         else if (accept) sent_cnt_o <= sent_cnt_o + CNT_W'(1);
      end
   end

`ifdef PARITY_INJECT_EN
   logic inj_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)         inj_q <= 1'b0;
      else if (load)     inj_q <= inj_i;
      else if (!valid_n) inj_q <= 1'b0;
   end

   assign data_p_o = parity32(data_o) ^ inj_q;
`else
   assign data_p_o = parity32(data_o);
`endif

   assign busy_o = (state != IDLE) || !empty;

endmodule

// File: tb/tb_chnl_master_node.sv
// tb/tb_chnl_master_node.sv - self-checking bench for chnl_master_node
module tb_chnl_master_node;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] push_data;
   logic        push;
   logic        full;
   logic [6:0]  freeslot;
   logic        en;
   logic [3:0]  gap;
   logic [31:0] data;
   logic        data_p;
   logic        valid;
   logic        wait_s;
   logic        parity_err;
   logic        busy;
   logic [15:0] sent_cnt;
   logic        cnt_clr;
   logic        inj = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [31:0] q[$];
   logic [15:0] exp_cnt = '0;
   bit          vh[$];
   bit          ph[$];
   bit          chk_par = 1'b1;

   chnl_master_node #(.DEPTH(DEPTH), .GAP_W(4)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .push_data_i  (push_data),
      .push_i       (push),
      .full_o       (full),
      .freeslot_o   (freeslot),
      .en_i         (en),
      .gap_i        (gap),
      .data_o       (data),
      .data_p_o     (data_p),
      .valid_o      (valid),
      .wait_i       (wait_s),
      .parity_err_i (parity_err),
      .busy_o       (busy),
      .sent_cnt_o   (sent_cnt),
      .cnt_clr_i    (cnt_clr)
`ifdef PARITY_INJECT_EN
      ,
      .inj_i        (inj)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int ones(input bit b[$]);
      int n = 0;
      foreach (b[i]) n += int'(b[i]);
      return n;
   endfunction

   // One clock: sample at the falling edge, score against the transaction model, advance.
   task automatic cycle();
      bit pop_m, push_m;
      @(negedge clk);
      check("freeslot", 32'(freeslot), 32'(DEPTH - q.size()));
      check("full", 32'(full), 32'(q.size() == DEPTH));
      check("sent_cnt", 32'(sent_cnt), 32'(exp_cnt));
      if (valid) check("head_word", data, (q.size() > 0) ? q[0] : ~data);
      if (chk_par) check("parity", 32'(data_p), 32'(^data));
      vh.push_back(valid);
      ph.push_back(data_p);
      pop_m  = valid && !wait_s && !parity_err;
      push_m = push && (q.size() < DEPTH || pop_m);
      if (pop_m) void'(q.pop_front());
      if (push_m) q.push_back(push_data);
      if (cnt_clr) exp_cnt = '0;
      else if (pop_m) exp_cnt = exp_cnt + 16'd1;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_cnt();
      cnt_clr = 1'b1;
      cycle();
      cnt_clr = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int k = 0;
      do begin
         cycle();
         k++;
      end while (vh[$] != 1'b1 && k < 20);
      check(tag, 32'(vh[$]), 32'd1);
   endtask

   initial begin
      int f;
      int idx[$];
      rst = 1'b1; push = 1'b0; push_data = '0; en = 1'b0; gap = '0;
      wait_s = 1'b0; parity_err = 1'b0; cnt_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_data", data, 32'd0);
      check("rst_parity", 32'(data_p), 32'd0);
      check("rst_full", 32'(full), 32'd0);
      check("rst_freeslot", 32'(freeslot), 32'd16);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_cnt", 32'(sent_cnt), 32'd0);
      rst = 1'b0;
      cycle();

      // two words back to back
      en = 1'b1;
      vh.delete(); ph.delete();
      push = 1'b1; push_data = 32'h1; cycle();
      push_data = 32'h3; cycle();
      push = 1'b0;
      repeat (4) cycle();
      check("t1_valid_cycles", 32'(ones(vh)), 32'd2);
      f = 0;
      foreach (vh[i]) if (vh[i] && f == 0) f = i;
      check("t1_contig", 32'(vh[f+1]), 32'd1);
      check("t1_par0", 32'(ph[f]), 32'd1);
      check("t1_par1", 32'(ph[f+1]), 32'd0);
      check("t1_cnt", 32'(sent_cnt), 32'd2);
      check("t1_free", 32'(freeslot), 32'd16);

      // held under wait for 5 cycles
      clear_cnt();
      vh.delete();
      wait_s = 1'b1;
      push = 1'b1; push_data = 32'hA5A5A5A5; cycle();
      push = 1'b0;
      wait_valid("t2_launch");
      repeat (4) cycle();
      wait_s = 1'b0;
      repeat (4) cycle();
      check("t2_valid_cycles", 32'(ones(vh)), 32'd6);
      check("t2_cnt", 32'(sent_cnt), 32'd1);

      // programmable gap of 3
      clear_cnt();
      gap = 4'd3;
      vh.delete();
      push = 1'b1;
      repeat (3) begin
         push_data = $urandom;
         cycle();
      end
      push = 1'b0;
      repeat (16) cycle();
      gap = 4'd0;
      idx.delete();
      foreach (vh[i]) if (vh[i]) idx.push_back(i);
      check("t3_pulses", 32'(idx.size()), 32'd3);
      if (idx.size() == 3) begin
         check("t3_gap_a", 32'(idx[1] - idx[0]), 32'd4);
         check("t3_gap_b", 32'(idx[2] - idx[1]), 32'd4);
      end
      check("t3_cnt", 32'(sent_cnt), 32'd3);

      // parity error while stalled
      clear_cnt();
      wait_s = 1'b1;
      push = 1'b1; push_data = $urandom; cycle();
      push = 1'b0;
      wait_valid("t4_launch");
      cycle();
      parity_err = 1'b1;
      cycle();
      cycle();
      check("t4_valid_drop", 32'(vh[$]), 32'd0);
      check("t4_free", 32'(freeslot), 32'd15);
      parity_err = 1'b0;
      wait_s = 1'b0;
      vh.delete();
      repeat (6) cycle();
      check("t4_resent_once", 32'(ones(vh)), 32'd1);
      check("t4_cnt", 32'(sent_cnt), 32'd1);

      // overfill while disabled, then drain in order
      clear_cnt();
      en = 1'b0;
      push = 1'b1;
      for (int i = 0; i < 17; i++) begin
         push_data = 32'h100 + 32'(i);
         cycle();
      end
      push = 1'b0;
      cycle();
      check("t5_full", 32'(full), 32'd1);
      check("t5_free0", 32'(freeslot), 32'd0);
      check("t5_last_kept", q[$], 32'h10F);
      en = 1'b1;
      for (int k = 0; k < 40 && q.size() > 0; k++) cycle();
      repeat (2) cycle();
      check("t5_cnt", 32'(sent_cnt), 32'd16);

`ifdef PARITY_INJECT_EN
      // inject on first zero word only
      chk_par = 1'b0;
      en = 1'b0;
      push = 1'b1; push_data = 32'h0;
      repeat (2) cycle();
      push = 1'b0;
      en = 1'b1; inj = 1'b1;
      vh.delete(); ph.delete();
      cycle();
      inj = 1'b0;
      repeat (4) cycle();
      idx.delete();
      foreach (vh[i]) if (vh[i]) idx.push_back(i);
      check("t6_pulses", 32'(idx.size()), 32'd2);
      if (idx.size() == 2) begin
         check("t6_inj", 32'(ph[idx[0]]), 32'd1);
         check("t6_clean", 32'(ph[idx[1]]), 32'd0);
      end
      chk_par = 1'b1;
`endif

      // randomized traffic against the scoreboard
      for (int n = 0; n < 500; n++) begin
         push      = ($urandom_range(0, 1) == 1);
         push_data = $urandom;
         wait_s    = ($urandom_range(0, 2) == 0);
         en        = ($urandom_range(0, 7) != 0);
         gap       = 4'($urandom_range(0, 2));
         cnt_clr   = ($urandom_range(0, 49) == 0);
         cycle();
      end
      push = 1'b0; cnt_clr = 1'b0; en = 1'b1; wait_s = 1'b0;
      for (int k = 0; k < 300 && q.size() > 0; k++) cycle();
      check("drain_empty", 32'(q.size()), 32'd0);
      repeat (5) cycle();
      check("drain_busy", 32'(busy), 32'd0);
      gap = '0;

      // reset in the middle of a stalled transfer
      wait_s = 1'b1;
      push = 1'b1;
      repeat (3) begin
         push_data = $urandom;
         cycle();
      end
      push = 1'b0;
      cycle();
      check("mr_valid_before", 32'(valid), 32'd1);
      rst = 1'b1;
      #2;
      check("mr_valid", 32'(valid), 32'd0);
      check("mr_free", 32'(freeslot), 32'd16);
      check("mr_busy", 32'(busy), 32'd0);
      check("mr_cnt", 32'(sent_cnt), 32'd0);
      q.delete();
      exp_cnt = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      wait_s = 1'b0;
      repeat (3) cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
